wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone classic responder implementing a 32-bit prescaled timer/compare unit. It sits on the MCU's Wishbone bus as the slave end of the spif bridge's master port, replacing the loopback stub. Its level interrupt feeds one `ipending` bit in the MCU's interrupt collector. It answers single-word reads and writes with a registered one-cycle acknowledge.

## Interface
Parameters:
- `BASE`, default 0: value `adr_i[14:3]` must equal for this block to respond.
- `ID`, default 32'h544D_5231: constant returned by the ID register.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `p_reset_n`, in, 1: reset, asynchronous, active-low.
- `adr_i`, in, 15: word address. `[14:3]` is the block select; `[2:0]` is the register index.
- `dat_i`, in, 32: write data from the master.
- `dat_o`, out, 32: read data to the master.
- `we_i`, in, 1: 1 means write, 0 means read. Qualified by `stb_i`.
- `stb_i`, in, 1: strobe. The master holds it until it sees `ack_o`, then drops it.
- `ack_o`, out, 1: one-cycle acknowledge.
- `irq`, out, 1: level interrupt, equal to STATUS.match & CTRL.ie.
- `tick`, out, 1: one-cycle pulse each time the prescaler expires.

## Operation
- **Accept condition**: `stb_i & ~ack_o & (adr_i[14:3]==BASE)`.
  - Non-matching addresses are never acknowledged. Top-level decode must guarantee a responder exists for every address the master can issue.
- **Register map** (index `adr_i[2:0]`):
  - 0 CTRL, R/W. Bit 0 `en`, bit 1 `auto` (autoreload), bit 2 `ie`. Other bits read 0.
  - 1 PRESCALE, R/W, 16 bits in `[15:0]`. Writing it also loads the prescale down-counter with the written value.
  - 2 COMPARE, R/W, 32 bits.
  - 3 COUNT. Read returns the live count. Write loads the count.
  - 4 STATUS. Bit 0 `match`. Writing 1 clears it; writing 0 has no effect.
  - 5 ID, read-only, returns `ID`.
  - 6 and 7: read 0, writes ignored, still acknowledged.
- **Prescaler**:
  - While `en`=1, the down-counter `pcnt` decrements each clock.
  - When `pcnt`==0: `tick`=1 for that cycle and `pcnt` reloads from PRESCALE. PRESCALE=0 therefore ticks every cycle; PRESCALE=N ticks every N+1 cycles.
  - While `en`=0, `pcnt` holds its value and `tick`=0.
- **Counter**: on `tick`, `count <= count+1`, wrapping mod 2^32 from FFFF_FFFF to 0.
  - If the incremented value equals COMPARE, set `match`.
  - If, additionally, `auto`=1, `count` becomes 0 instead of COMPARE.
- **Simultaneous events**:
  - A bus write to COUNT in a tick cycle: the written value wins, and no match is evaluated that cycle.
  - A STATUS clear in the same cycle a match sets: set wins, so `match` stays 1.
  - A write to PRESCALE in a tick cycle: the written value loads `pcnt`.
  - A write to COMPARE takes effect for comparisons from the next tick.
- **Reset values**:
  - All registers, `pcnt` and `count` reset to 0.
  - `dat_o`=0, `ack_o`=0, `irq`=0, `tick`=0.
  - Reset mid-transaction drops `ack_o` immediately. The master must re-issue the access.

## Timing
- Let cycle A be the cycle in which the accept condition holds, and edge A the clock edge that ends it.
  - A write's register update occurs at edge A.
  - A read samples its register at edge A and registers the result into `dat_o`.
- `ack_o`=1 during cycle A+1 only. `dat_o` is valid in that cycle and holds until the next accepted read.
- `stb_i` still high during A+1 is not re-accepted, because `ack_o` is 1.
  - If `stb_i` stays high into cycle A+2, that is a new transaction, accepted at A+2.
  - Maximum throughput is one access per 2 cycles.
- Read-after-write to the same register in back-to-back transactions returns the new value.
- `irq` is registered and follows `match`/`ie` changes one cycle later. No combinational path exists from `stb_i` to `ack_o`.

## Structure
- The shared package `wb_timer_pkg` holds:
  - register index constants: `R_CTRL`=0, `R_PRE`=1, `R_CMP`=2, `R_CNT`=3, `R_STAT`=4, `R_ID`=5;
  - CTRL bit positions: `EN`=0, `AUTO`=1, `IE`=2.
- One sub-module, `wb_prescaler`, contains the 16-bit down-counter, its load port, `en`, and the `tick` output.
- The bus FSM is two states: IDLE and ACK. ACK always returns to IDLE.
- `wb_timer` instantiates `wb_prescaler`. Its `irq` connects to the MCU's `ipending[4]`.

## Test plan
- **Reset state**: reset, then read ID. `ack_o` pulses at A+1 with `dat_o`=544D_5231. A read of CTRL returns 0. `irq`=0.
- **Prescaler period**: write PRESCALE=3, CTRL=1. `tick` pulses every 4 cycles. COUNT read after 40 cycles is 10 (±1 per the documented phase).
- **Autoreload compare**: PRESCALE=0, COMPARE=5, CTRL=7. `match` and `irq` assert; count sequence is 0..4 then 0. Writing STATUS=1 clears `irq` one cycle later.
- **Wrap-around**: write COUNT=FFFF_FFFF, COMPARE=2, CTRL=1. Count goes to 0, then 1, then 2, and `match` sets at 2.
- **Collisions**:
  - COUNT write of 100 in a tick cycle leaves COUNT=100.
  - STATUS clear coincident with a match leaves `match`=1.
- **Handshake**:
  - `stb_i` held 3 cycles yields two acks, at A+1 and A+3.
  - A non-matching BASE gets no ack within 10 cycles.
  - Asserting `p_reset_n` low during the ACK cycle forces `ack_o`=0 immediately.

Source files
------------

// File: rtl/wb_timer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// wb_timer_pkg: register indices, CTRL bit positions and bus FSM state type
// Revision 1.0
// ----------------------------------------------------------------------------
package wb_timer_pkg;

  localparam logic [2:0] R_CTRL = 3'd0;
  localparam logic [2:0] R_PRE  = 3'd1;
  localparam logic [2:0] R_CMP  = 3'd2;
  localparam logic [2:0] R_CNT  = 3'd3;
  localparam logic [2:0] R_STAT = 3'd4;
  localparam logic [2:0] R_ID   = 3'd5;

  localparam int EN   = 0;
  localparam int AUTO = 1;
  localparam int IE   = 2;

  localparam logic [31:0] ID_DEFAULT = 32'h544D_5231;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'd0, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// wb_timer_if: Wishbone classic single-word bus between master and wb_timer
// Revision 1.0
// ----------------------------------------------------------------------------
interface wb_timer_if;

  logic [14:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic        stb_i;
  logic        ack_o;

  modport master (
    output adr_i,
    output dat_i,
    output we_i,
    output stb_i,
    input  dat_o,
    input  ack_o
  );

  modport slave (
    input  adr_i,
    input  dat_i,
    input  we_i,
    input  stb_i,
    output dat_o,
    output ack_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// wb_prescaler: 16-bit down-counter, pulses tick on the cycle it reads zero
// Revision 1.0
// ----------------------------------------------------------------------------
module wb_prescaler (
  input  wire        clk,
  input  wire        p_reset_n,
  input  wire        en,
  input  wire        load,
  input  wire [15:0] load_val,
  input  wire [15:0] reload_val,
  output logic       tick
);

  logic [15:0] pcnt_q;
  logic [15:0] pcnt_d;

  // A bus load overrides both the expiry reload and the normal decrement.
  always_comb begin
    tick   = en & (pcnt_q == 16'd0);
    pcnt_d = pcnt_q;
    if (load) begin
      pcnt_d = load_val;
    end else if (tick) begin
      pcnt_d = reload_val;
    end else if (en) begin
      pcnt_d = pcnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      pcnt_q <= 16'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// wb_timer: Wishbone classic responder for a 32-bit prescaled timer/compare
// Revision 1.0
// ----------------------------------------------------------------------------
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [11:0] BASE = 12'd0,
  parameter logic [31:0] ID   = ID_DEFAULT
) (
  input  wire        clk,
  input  wire        p_reset_n,
  wb_timer_if.slave  bus,
  output logic       irq,
  output logic       tick
);

  bus_state_e  state_q;
  logic        ack_q;
  logic [31:0] dat_o_q;

  logic [2:0]  ctrl_q,  ctrl_d;
  logic [15:0] pre_q,   pre_d;
  logic [31:0] cmp_q,   cmp_d;
  logic [31:0] count_q, count_d;
  logic        match_q, match_d;
  logic        irq_q,   irq_d;

  logic [2:0]  idx;
  logic        sel;
  logic        accept;
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_pre;
  logic        wr_cmp;
  logic        wr_cnt;
  logic        wr_stat;
  logic [31:0] rdata;
  logic [31:0] count_inc;
  logic        hit;

  always_comb begin
    idx     = bus.adr_i[2:0];
    sel     = (bus.adr_i[14:3] == BASE);
    accept  = bus.stb_i & ~ack_q & sel;
    wr      = accept & bus.we_i;
    rd      = accept & ~bus.we_i;
    wr_ctrl = wr & (idx == R_CTRL);
    wr_pre  = wr & (idx == R_PRE);
    wr_cmp  = wr & (idx == R_CMP);
    wr_cnt  = wr & (idx == R_CNT);
    wr_stat = wr & (idx == R_STAT);
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      R_CTRL:  rdata = {29'd0, ctrl_q};
      R_PRE:   rdata = zext16(pre_q);
      R_CMP:   rdata = cmp_q;
      R_CNT:   rdata = count_q;
      R_STAT:  rdata = {31'd0, match_q};
      R_ID:    rdata = ID;
      default: rdata = 32'd0;
    endcase
  end

  wb_prescaler u_prescaler (
    .clk        (clk),
    .p_reset_n  (p_reset_n),
    .en         (ctrl_q[EN]),
    .load       (wr_pre),
    .load_val   (bus.dat_i[15:0]),
    .reload_val (pre_q),
    .tick       (tick)
  );

  // A COUNT write suppresses both the increment and the compare; a new match
  // outranks a simultaneous STATUS clear.
  always_comb begin
    ctrl_d    = wr_ctrl ? bus.dat_i[2:0]  : ctrl_q;
    pre_d     = wr_pre  ? bus.dat_i[15:0] : pre_q;
    cmp_d     = wr_cmp  ? bus.dat_i       : cmp_q;
    count_inc = count_q + 32'd1;
    hit       = tick & ~wr_cnt & (count_inc == cmp_q);
    count_d   = count_q;
    if (wr_cnt) begin
      count_d = bus.dat_i;
    end else if (tick) begin
      count_d = (hit & ctrl_q[AUTO]) ? 32'd0 : count_inc;
    end
    match_d = hit | (match_q & ~(wr_stat & bus.dat_i[0]));
    irq_d   = match_q & ctrl_q[IE];
  end

  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      ctrl_q  <= 3'd0;
      pre_q   <= 16'd0;
      cmp_q   <= 32'd0;
      count_q <= 32'd0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      pre_q   <= pre_d;
      cmp_q   <= cmp_d;
      count_q <= count_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end

  // Read data is captured at the accept edge so it reflects pre-write state.
  always_ff @(posedge clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            if (rd) begin
              dat_o_q <= rdata;
            end
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_o_q;
  assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wb_timer: table, directed and random checks of wb_timer against a model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_wb_timer;
  import wb_timer_pkg::*;

  localparam logic [11:0] C_BASE = 12'h0A5;
  localparam logic [31:0] C_ID   = 32'h544D_5231;

  logic clk = 1'b0;
  logic p_reset_n;
  logic irq;
  logic tick;

  wb_timer_if bus ();

  wb_timer #(.BASE(C_BASE), .ID(C_ID)) dut (
    .clk       (clk),
    .p_reset_n (p_reset_n),
    .bus       (bus),
    .irq       (irq),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          we;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [31:0] expv;
  } vec_t;
  vec_t tbl [0:19];

  // Reference model state, named after the programmer-visible registers
  bit          m_en, m_auto, m_ie, m_match, m_irq, m_ack;
  logic [15:0] m_pre, m_pcnt;
  logic [31:0] m_cmp, m_cnt, m_dato;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_match = 0; m_irq = 0; m_ack = 0;
    m_pre = 0; m_pcnt = 0; m_cmp = 0; m_cnt = 0; m_dato = 0;
  endtask

  function automatic logic [31:0] m_reg(input int idx);
    case (idx)
      0:       return {29'd0, m_ie, m_auto, m_en};
      1:       return {16'd0, m_pre};
      2:       return m_cmp;
      3:       return m_cnt;
      4:       return {31'd0, m_match};
      5:       return C_ID;
      default: return 32'd0;
    endcase
  endfunction

  // One rising edge of the timer, computed from the register-level rules
  task automatic model_edge();
    bit acc, wr, tk, setm, new_irq;
    int idx;
    logic [31:0] d;
    longint nxt;
    acc     = bus.stb_i && !m_ack && (bus.adr_i[14:3] == C_BASE);
    wr      = acc && bus.we_i;
    idx     = int'(bus.adr_i[2:0]);
    d       = bus.dat_i;
    tk      = m_en && (m_pcnt == 16'd0);
    new_irq = m_match && m_ie;
    if (acc && !bus.we_i) m_dato = m_reg(idx);
    m_ack = acc;
    if (wr && idx == 1)  m_pcnt = d[15:0];
    else if (tk)         m_pcnt = m_pre;
    else if (m_en)       m_pcnt = m_pcnt - 16'd1;
    setm = 0;
    if (wr && idx == 3) begin
      m_cnt = d;
    end else if (tk) begin
      nxt = (longint'(m_cnt) + 1) % 64'h1_0000_0000;
      if (nxt == longint'(m_cmp)) begin
        setm = 1;
        if (m_auto) nxt = 0;
      end
      m_cnt = nxt[31:0];
    end
    m_match = setm || (m_match && !(wr && idx == 4 && d[0]));
    if (wr && idx == 0) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
    end
    if (wr && idx == 1) m_pre = d[15:0];
    if (wr && idx == 2) m_cmp = d;
    m_irq = new_irq;
  endtask

  task automatic step();
    @(posedge clk);
    if (!p_reset_n) model_reset();
    else model_edge();
    #1;
    cyc++;
    chk("ack_o", bus.ack_o, m_ack);
    chk("dat_o", bus.dat_o, m_dato);
    chk("tick", tick, m_en && (m_pcnt == 16'd0));
    chk("irq", irq, m_irq);
  endtask

  task automatic bus_op(input bit we, input logic [2:0] idx, input logic [31:0] d);
    bus.adr_i = {C_BASE, idx};
    bus.we_i  = we;
    bus.dat_i = d;
    bus.stb_i = 1'b1;
    step();
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    step();
  endtask

  task automatic do_reset();
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    p_reset_n = 1'b0;
    #1;
    chk("rst_ack", bus.ack_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tick", tick, 0);
    model_reset();
    step();
    step();
    p_reset_n = 1'b1;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    bit ok;
    logic [31:0] v;
    logic [2:0]  acks;
    logic [31:0] seen [$];

    bus.adr_i = '0; bus.dat_i = '0; bus.we_i = 1'b0; bus.stb_i = 1'b0;
    p_reset_n = 1'b0;

    tbl[0]  = '{1'b0, R_ID,   32'h0,         C_ID};
    tbl[1]  = '{1'b0, R_CTRL, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, R_PRE,  32'h0,         32'h0};
    tbl[3]  = '{1'b0, R_CMP,  32'h0,         32'h0};
    tbl[4]  = '{1'b0, R_CNT,  32'h0,         32'h0};
    tbl[5]  = '{1'b0, R_STAT, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, R_CMP,  32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b0, R_CMP,  32'h0,         32'hDEAD_BEEF};
    tbl[8]  = '{1'b1, R_PRE,  32'h0001_ABCD, 32'h0};
    tbl[9]  = '{1'b0, R_PRE,  32'h0,         32'h0000_ABCD};
    tbl[10] = '{1'b1, R_CTRL, 32'hFFFF_FFF6, 32'h0};
    tbl[11] = '{1'b0, R_CTRL, 32'h0,         32'h0000_0006};
    tbl[12] = '{1'b1, R_CNT,  32'h1234_5678, 32'h0};
    tbl[13] = '{1'b0, R_CNT,  32'h0,         32'h1234_5678};
    tbl[14] = '{1'b1, R_ID,   32'h0,         32'h0};
    tbl[15] = '{1'b0, R_ID,   32'h0,         C_ID};
    tbl[16] = '{1'b1, 3'd6,   32'hFFFF_FFFF, 32'h0};
    tbl[17] = '{1'b0, 3'd6,   32'h0,         32'h0};
    tbl[18] = '{1'b0, 3'd7,   32'h0,         32'h0};
    tbl[19] = '{1'b1, R_STAT, 32'h1,         32'h0};

    @(posedge clk);
    #1;
    do_reset();
    chk("reset_irq", irq, 0);
    foreach (tbl[i]) begin
      bus_op(tbl[i].we, tbl[i].idx, tbl[i].data);
      if (!tbl[i].we) chk($sformatf("tbl[%0d]", i), bus.dat_o, tbl[i].expv);
    end

    // Prescaler period: PRESCALE=3 gives one tick every 4 cycles
    do_reset();
    bus_op(1, R_PRE, 32'd3);
    bus_op(1, R_CTRL, 32'd1);
    n = 0; last = -1; ok = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (tick) begin
        if (last >= 0 && (k - last) != 4) ok = 0;
        last = k;
        n++;
      end
    end
    chk("pre_ticks", n, 10);
    chk("pre_gap4", ok, 1);
    bus_op(0, R_CNT, 0);
    v = bus.dat_o;
    chk("pre_count_9_11", (v >= 9 && v <= 11), 1);

    // Autoreload compare
    do_reset();
    bus_op(1, R_PRE, 32'd0);
    bus_op(1, R_CMP, 32'd5);
    bus_op(1, R_CTRL, 32'd7);
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (irq) ok = 1;
    end
    chk("auto_irq_set", ok, 1);
    for (int k = 0; k < 6; k++) begin
      bus_op(0, R_CNT, 0);
      chk("auto_cnt_le4", bus.dat_o <= 32'd4, 1);
    end
    bus_op(1, R_CTRL, 32'd4);
    chk("auto_irq_held", irq, 1);
    bus_op(1, R_STAT, 32'd1);
    chk("auto_irq_clr", irq, 0);

    // Wrap-around from FFFF_FFFF
    do_reset();
    bus_op(1, R_PRE, 32'd3);
    bus_op(1, R_CNT, 32'hFFFF_FFFF);
    bus_op(1, R_CMP, 32'd2);
    bus_op(1, R_CTRL, 32'd1);
    seen.delete();
    repeat (12) begin
      bus_op(0, R_CNT, 0);
      if (seen.size() == 0 || seen[seen.size()-1] != bus.dat_o) seen.push_back(bus.dat_o);
    end
    chk("wrap_len", seen.size() >= 4, 1);
    if (seen.size() >= 4) begin
      chk("wrap_v0", seen[0], 32'hFFFF_FFFF);
      chk("wrap_v1", seen[1], 32'd0);
      chk("wrap_v2", seen[2], 32'd1);
      chk("wrap_v3", seen[3], 32'd2);
    end
    bus_op(0, R_STAT, 0);
    chk("wrap_match", bus.dat_o, 32'd1);

    // COUNT write landing in a tick cycle
    do_reset();
    bus_op(1, R_PRE, 32'd3);
    bus_op(1, R_CTRL, 32'd1);
    ok = 0;
    for (int k = 0; k < 12 && !ok; k++) begin
      if (m_en && m_pcnt == 16'd0) ok = 1;
      else step();
    end
    chk("cnt_coll_sync", ok, 1);
    chk("cnt_coll_tick", tick, 1);
    bus_op(1, R_CNT, 32'd100);
    bus_op(0, R_CNT, 0);
    chk("cnt_coll_val", bus.dat_o, 32'd100);

    // STATUS clear coinciding with a new match
    do_reset();
    bus_op(1, R_PRE, 32'd3);
    bus_op(1, R_CNT, 32'd50);
    bus_op(1, R_CMP, 32'd51);
    bus_op(1, R_CTRL, 32'd1);
    ok = 0;
    for (int k = 0; k < 12 && !ok; k++) begin
      if (m_en && m_pcnt == 16'd0) ok = 1;
      else step();
    end
    chk("stat_coll_sync", ok, 1);
    bus_op(1, R_STAT, 32'd1);
    bus_op(0, R_STAT, 0);
    chk("stat_coll_match", bus.dat_o, 32'd1);

    // Strobe held three cycles: acks at A+1 and A+3
    do_reset();
    bus.adr_i = {C_BASE, R_ID};
    bus.we_i  = 1'b0;
    bus.stb_i = 1'b1;
    acks = 3'b000;
    repeat (3) begin
      step();
      acks = {acks[1:0], bus.ack_o};
    end
    bus.stb_i = 1'b0;
    step();
    chk("hs_acks", {29'd0, acks}, 32'd5);
    chk("hs_dat", bus.dat_o, C_ID);

    // Non-matching block select is never acknowledged
    bus.adr_i = {C_BASE ^ 12'h001, R_ID};
    bus.stb_i = 1'b1;
    n = 0;
    repeat (10) begin
      step();
      if (bus.ack_o) n++;
    end
    bus.stb_i = 1'b0;
    step();
    chk("nomatch_acks", n, 0);

    // Reset asserted during the ACK cycle
    bus.adr_i = {C_BASE, R_ID};
    bus.stb_i = 1'b1;
    step();
    chk("rack_pre", bus.ack_o, 1);
    #2;
    p_reset_n = 1'b0;
    #1;
    chk("rack_ack", bus.ack_o, 0);
    chk("rack_dat", bus.dat_o, 0);
    model_reset();
    bus.stb_i = 1'b0;
    step();
    p_reset_n = 1'b1;
    step();

    // Random traffic against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      int r;
      int hold;
      logic [2:0]  ri;
      logic [31:0] rdat;
      bit rwe;
      repeat ($urandom_range(0, 2)) step();
      r    = $urandom_range(0, 99);
      ri   = 3'($urandom_range(0, 7));
      rwe  = ($urandom_range(0, 1) == 1);
      case (ri)
        R_CTRL:  rdat = ($urandom_range(0, 9) < 8) ? ($urandom | 32'd1) : $urandom;
        R_PRE:   rdat = $urandom_range(0, 4) | ($urandom & 32'hFFFF_0000);
        R_CMP:   rdat = $urandom_range(0, 40);
        R_CNT:   rdat = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 30);
        default: rdat = $urandom;
      endcase
      bus.adr_i = {((r < 5) ? (C_BASE ^ 12'h001) : C_BASE), ri};
      bus.we_i  = rwe;
      bus.dat_i = rdat;
      bus.stb_i = 1'b1;
      hold = (r >= 95) ? 3 : 1;
      repeat (hold) step();
      bus.stb_i = 1'b0;
      bus.we_i  = 1'b0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
